// File: rtl/fpu_pkg.sv
// Shared FPU types and sizing for the add/sub path.
// Alignment stage constants and FSM state encoding.
package fpu_pkg;
  localparam int N_MANT = 25;
  localparam int N_EXP  = 8;
  localparam int DMAX   = N_MANT + 1;
  localparam int CW     = $clog2(DMAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } align_state_t;
endpackage

// File: rtl/mantissa_aligner_if.sv
// Operand/result handshake bundle for the mantissa aligner.
// master drives operands and out_ready; slave is the aligner.
interface mantissa_aligner_if
  import fpu_pkg::*;
#(
  parameter int N_mant = N_MANT,
  parameter int N_exp  = N_EXP
);
  logic              in_valid;
  logic              in_ready;
  logic [N_mant-2:0] mantissa_a;
  logic [N_mant-2:0] mantissa_b;
  logic [N_exp-1:0]  expoente_a;
  logic [N_exp-1:0]  expoente_b;
  logic              out_valid;
  logic              out_ready;
  logic [N_mant-2:0] mantissa_big;
  logic [N_mant-2:0] mantissa_small;
  logic              guard;
  logic              round;
  logic              sticky;
  logic [N_exp-1:0]  expoente_out;
  logic              swapped;

  modport master (
    output in_valid, mantissa_a, mantissa_b,
    output expoente_a, expoente_b, out_ready,
    input  in_ready, out_valid,
    input  mantissa_big, mantissa_small,
    input  guard, round, sticky,
    input  expoente_out, swapped
  );

  modport slave (
    input  in_valid, mantissa_a, mantissa_b,
    input  expoente_a, expoente_b, out_ready,
    output in_ready, out_valid,
    output mantissa_big, mantissa_small,
    output guard, round, sticky,
    output expoente_out, swapped
  );
endinterface

// File: rtl/exp_comparator.sv
// Picks the larger-exponent operand and the shift distance,
// clamped so the small mantissa fully drains into sticky.
module exp_comparator
  import fpu_pkg::*;
#(
  parameter int N_exp  = N_EXP,
  parameter int N_mant = N_MANT,
  parameter int DW     = $clog2(N_mant + 2)
) (
  input  logic [N_exp-1:0] exp_a,
  input  logic [N_exp-1:0] exp_b,
  output logic             swap,
  output logic [N_exp-1:0] exp_big,
  output logic [DW-1:0]    diff
);
  logic [N_exp:0] dfull;

  always_comb begin
    swap    = exp_a < exp_b;
    exp_big = swap ? exp_b : exp_a;
    dfull   = swap ? {1'b0, exp_b} - {1'b0, exp_a}
                   : {1'b0, exp_a} - {1'b0, exp_b};
    if (dfull > (N_exp + 1)'(N_mant + 1))
      diff = DW'(N_mant + 1);
    else
      diff = dfull[DW-1:0];
  end
endmodule

// File: rtl/mantissa_aligner.sv
// Iterative pre-adder aligner: shifts the small mantissa
// right one bit per cycle, collecting guard/round/sticky.
module mantissa_aligner
  import fpu_pkg::*;
#(
  parameter int N_mant = N_MANT,
  parameter int N_exp  = N_EXP
) (
  input  logic clk,
  input  logic rst_n,
  mantissa_aligner_if.slave io
);
  localparam int DW = $clog2(N_mant + 2);
  localparam int MW = N_mant - 1;

  align_state_t     state;
  align_state_t     state_nx;
  logic             live;
  logic             accept;
  logic             swap;
  logic [N_exp-1:0] exp_big;
  logic [DW-1:0]    diff;
  logic [DW-1:0]    cnt;
  logic [N_mant:0]  sh;
  logic             stk;
  logic [MW-1:0]    big_q;
  logic [N_exp-1:0] exp_q;
  logic             swp_q;

  exp_comparator #(
    .N_exp  (N_exp),
    .N_mant (N_mant),
    .DW     (DW)
  ) u_cmp (
    .exp_a   (io.expoente_a),
    .exp_b   (io.expoente_b),
    .swap    (swap),
    .exp_big (exp_big),
    .diff    (diff)
  );

  // live keeps in_ready low through reset
  assign io.in_ready  = live && (state == IDLE);
  assign io.out_valid = (state == DONE);
  assign accept       = io.in_ready && io.in_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      live  <= 1'b0;
    end else begin
      state <= state_nx;
      live  <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (accept)
          state_nx = (diff != '0) ? SHIFT : DONE;
      SHIFT:
        if (cnt == DW'(1))
          state_nx = DONE;
      DONE:
        if (io.out_ready)
          state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh    <= '0;
      stk   <= 1'b0;
      cnt   <= '0;
      big_q <= '0;
      exp_q <= '0;
      swp_q <= 1'b0;
    end else if (accept) begin
      sh    <= {swap ? io.mantissa_a : io.mantissa_b, 2'b00};
      stk   <= 1'b0;
      cnt   <= diff;
      big_q <= swap ? io.mantissa_b : io.mantissa_a;
      exp_q <= exp_big;
      swp_q <= swap;
    end else if (state == SHIFT) begin
      sh  <= sh >> 1;
      stk <= stk | sh[0];
      cnt <= cnt - 1'b1;
    end
  end

  assign io.mantissa_big   = big_q;
  assign io.mantissa_small = sh[N_mant:2];
  assign io.guard          = sh[1];
  assign io.round          = sh[0];
  assign io.sticky         = stk;
  assign io.expoente_out   = exp_q;
  assign io.swapped        = swp_q;
endmodule
